// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths
// and the architectural zero register.
`ifndef RF_WRITE_ARBITER_DEFS
`define RF_WRITE_ARBITER_DEFS
`define RF_DATA_W 32
`define RF_ADDR_W 5
`endif

package rf_write_arbiter_pkg;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of producer handshakes, register-file write port and hazard queries.
// Handshake: a transfer happens in a cycle where valid && ready are both high at clk rise.
interface rf_write_arbiter_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 2
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              regWrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] q_rs;
    logic [ADDR_W-1:0] q_rt;
    logic              q_rs_pending;
    logic              q_rt_pending;
    logic [CNT_W-1:0]  b_count;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rs, q_rt,
        input  a_ready, b_ready, regWrite, rd, writeData,
               q_rs_pending, q_rt_pending, b_count
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rs, q_rt,
        output a_ready, b_ready, regWrite, rd, writeData,
               q_rs_pending, q_rt_pending, b_count
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// In-order shift FIFO of {rd, data}; entry 0 is always the head.
// Also reports which valid entries target each of three query addresses.
module rf_wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_rd,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] q_a,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic [DEPTH-1:0]  match_a,
    output logic [DEPTH-1:0]  match_rs,
    output logic [DEPTH-1:0]  match_rt
);
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [ADDR_W-1:0] rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  wr_idx;

    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        wr_idx  = count_q - CNT_W'(pop);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                rd_d[i]   = rd_q[i+1];
                data_d[i] = data_q[i+1];
            end
        end
        // The write slot accounts for a same-cycle pop shifting everything down.
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (CNT_W'(i) == wr_idx)) begin
                rd_d[i]   = push_rd;
                data_d[i] = push_data;
            end
        end
    end

    always_comb begin
        match_a  = '0;
        match_rs = '0;
        match_rt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                match_a[i]  = (rd_q[i] == q_a);
                match_rs[i] = (rd_q[i] == q_rs);
                match_rt[i] = (rd_q[i] == q_rt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign head_rd   = rd_q[0];
    assign head_data = data_q[0];
    assign count     = count_q;
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the ALU (A, priority,
// unbuffered) and the load/multi-cycle unit (B, buffered, anti-starvation).
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = `RF_DATA_W,
    parameter int ADDR_W     = `RF_ADDR_W,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              reset,
    rf_write_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [CNT_W-1:0]     fifo_count;
    logic [ADDR_W-1:0]    head_rd;
    logic [DATA_W-1:0]    head_data;
    logic [BUF_DEPTH-1:0] match_a, match_rs, match_rt;
    logic fifo_empty, fifo_full, force_b, a_hazard, a_ready, a_grant;
    logic fifo_pop, fifo_push;

    logic [SW-1:0]     starve_q, starve_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    rf_wb_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_rd  (bus.b_rd),
        .push_data(bus.b_data),
        .pop      (fifo_pop),
        .head_rd  (head_rd),
        .head_data(head_data),
        .count    (fifo_count),
        .q_a      (bus.a_rd),
        .q_rs     (bus.q_rs),
        .q_rt     (bus.q_rt),
        .match_a  (match_a),
        .match_rs (match_rs),
        .match_rt (match_rt)
    );

    // Full ignores a same-cycle pop so b_ready never depends on a_valid.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == CNT_W'(BUF_DEPTH));
        force_b    = !fifo_empty && (starve_q == SW'(STARVE_MAX));
        a_hazard   = (bus.a_rd != ZERO) && (|match_a);
        a_ready    = !force_b && !a_hazard;
        // An accepted write to $zero is dropped and leaves the port to the FIFO.
        a_grant    = bus.a_valid && a_ready && (bus.a_rd != ZERO);
        fifo_pop   = !fifo_empty && !a_grant;
        fifo_push  = bus.b_valid && !fifo_full && (bus.b_rd != ZERO);
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        if (a_grant) begin
            regwrite_d = 1'b1;
            rd_d       = bus.a_rd;
            wdata_d    = bus.a_data;
        end else if (fifo_pop) begin
            regwrite_d = 1'b1;
            rd_d       = head_rd;
            wdata_d    = head_data;
        end
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (a_grant && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.a_ready      = a_ready;
    assign bus.b_ready      = !fifo_full;
    assign bus.regWrite     = regwrite_q;
    assign bus.rd           = rd_q;
    assign bus.writeData    = wdata_q;
    assign bus.b_count      = fifo_count;
    assign bus.q_rs_pending = (bus.q_rs != ZERO) && ((|match_rs) || (regwrite_q && (rd_q == bus.q_rs)));
    assign bus.q_rt_pending = (bus.q_rt != ZERO) && ((|match_rt) || (regwrite_q && (rd_q == bus.q_rt)));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model of
// the write arbiter.
module tb_rf_write_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int BUF_DEPTH  = 2;
  localparam int STARVE_MAX = 4;
  localparam int ENT_W      = ADDR_W + DATA_W;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [ENT_W-1:0] exp_q[$];

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)) bus ();

  rf_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
    bus.q_rs = '0; bus.q_rt = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic bit model_holds(input logic [ADDR_W-1:0] r);
    foreach (exp_q[i]) if (exp_q[i][ENT_W-1:DATA_W] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b want 0", bus.regWrite); end
    checks++; if (bus.rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.rd); end
    checks++; if (bus.writeData !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", bus.writeData); end
    checks++; if (bus.b_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.b_count); end
    checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %0b want 1", bus.b_ready); end
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %0b want 1", bus.a_ready); end
  endtask

  task automatic test_a_only();
    do_reset();
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'd9;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready: got %0b want 1", bus.a_ready); end
    tick();
    bus.a_valid = 1'b0;
    checks++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd3 || bus.writeData !== 32'd9) begin
      errors++; $display("FAIL a_only_write: got we=%0b rd=%0d d=%0h want we=1 rd=3 d=9", bus.regWrite, bus.rd, bus.writeData); end
    tick();
    checks++; if (bus.regWrite !== 1'b0 || bus.rd !== 5'd3 || bus.writeData !== 32'd9) begin
      errors++; $display("FAIL a_only_hold: got we=%0b rd=%0d d=%0h want we=0 rd=3 d=9", bus.regWrite, bus.rd, bus.writeData); end
  endtask

  task automatic test_starvation();
    do_reset();
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 32'd100;
    bus.b_valid = 1'b1; bus.b_rd = 5'd5; bus.b_data = 32'd7;
    tick();
    bus.b_rd = 5'd6; bus.b_data = 32'd8;
    tick();
    bus.b_valid = 1'b0;
    #1;
    checks++; if (bus.b_count !== 2'd2 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL starve_full: got count=%0d b_ready=%0b want 2/0", bus.b_count, bus.b_ready); end
    for (int k = 0; k < STARVE_MAX - 1; k++) begin
      checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL starve_a_wins%0d: got %0b want 1", k, bus.a_ready); end
      tick();
    end
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL starve_forced: got a_ready=%0b want 0", bus.a_ready); end
    tick();
    checks++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd5 || bus.writeData !== 32'd7 || bus.b_count !== 2'd1) begin
      errors++; $display("FAIL starve_head: got we=%0b rd=%0d d=%0h cnt=%0d want 1/5/7/1", bus.regWrite, bus.rd, bus.writeData, bus.b_count); end
    bus.a_valid = 1'b0;
    tick();
    checks++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd6 || bus.writeData !== 32'd8) begin
      errors++; $display("FAIL starve_second: got we=%0b rd=%0d d=%0h want 1/6/8", bus.regWrite, bus.rd, bus.writeData); end
  endtask

  task automatic test_order_hazard();
    do_reset();
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'd1;
    tick();
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'd2;
    #1;
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL hazard_block: got a_ready=%0b want 0", bus.a_ready); end
    tick();
    checks++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd7 || bus.writeData !== 32'd1) begin
      errors++; $display("FAIL hazard_old_first: got we=%0b rd=%0d d=%0h want 1/7/1", bus.regWrite, bus.rd, bus.writeData); end
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got a_ready=%0b want 1", bus.a_ready); end
    tick();
    bus.a_valid = 1'b0;
    checks++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd7 || bus.writeData !== 32'd2) begin
      errors++; $display("FAIL hazard_new_second: got we=%0b rd=%0d d=%0h want 1/7/2", bus.regWrite, bus.rd, bus.writeData); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h55;
    tick();
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hAA;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL zero_a_ready: got %0b want 1", bus.a_ready); end
    tick();
    bus.a_valid = 1'b0;
    checks++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd9 || bus.writeData !== 32'h55 || bus.b_count !== 2'd0) begin
      errors++; $display("FAIL zero_head_pop: got we=%0b rd=%0d d=%0h cnt=%0d want 1/9/55/0", bus.regWrite, bus.rd, bus.writeData, bus.b_count); end
    bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h77;
    #1;
    checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL zero_b_ready: got %0b want 1", bus.b_ready); end
    tick();
    bus.b_valid = 1'b0;
    checks++; if (bus.b_count !== 2'd0) begin errors++; $display("FAIL zero_b_dropped: got count=%0d want 0", bus.b_count); end
    tick();
    checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL zero_no_write: got we=%0b want 0", bus.regWrite); end
  endtask

  task automatic test_pending();
    do_reset();
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 32'd3;
    bus.b_valid = 1'b1; bus.b_rd = 5'd12; bus.b_data = 32'h12;
    tick();
    bus.b_valid = 1'b0;
    bus.q_rs = 5'd12; bus.q_rt = 5'd0;
    #1;
    checks++; if (bus.q_rs_pending !== 1'b1 || bus.q_rt_pending !== 1'b0) begin
      errors++; $display("FAIL pend_fifo: got rs=%0b rt=%0b want 1/0", bus.q_rs_pending, bus.q_rt_pending); end
    bus.q_rt = 5'd4;
    #1;
    checks++; if (bus.q_rt_pending !== 1'b1) begin errors++; $display("FAIL pend_regwrite: got rt=%0b want 1", bus.q_rt_pending); end
    bus.q_rt = 5'd0;
    bus.a_valid = 1'b0;
    tick();
    checks++; if (bus.q_rs_pending !== 1'b1 || bus.rd !== 5'd12) begin
      errors++; $display("FAIL pend_retiring: got rs=%0b rd=%0d want 1/12", bus.q_rs_pending, bus.rd); end
    tick();
    checks++; if (bus.q_rs_pending !== 1'b0 || bus.q_rt_pending !== 1'b0) begin
      errors++; $display("FAIL pend_clear: got rs=%0b rt=%0b want 0/0", bus.q_rs_pending, bus.q_rt_pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 32'd5;
    bus.b_valid = 1'b1; bus.b_rd = 5'd20; bus.b_data = 32'h111;
    tick();
    bus.b_rd = 5'd21; bus.b_data = 32'h222;
    tick();
    bus.b_valid = 1'b0;
    #1;
    checks++; if (bus.b_count !== 2'd2 || bus.regWrite !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: got cnt=%0d we=%0b want 2/1", bus.b_count, bus.regWrite); end
    bus.a_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.regWrite !== 1'b0 || bus.b_count !== 2'd0 || bus.b_ready !== 1'b1 || bus.rd !== 5'd0 || bus.writeData !== 32'd0) begin
      errors++; $display("FAIL midrst_state: got we=%0b cnt=%0d b_ready=%0b rd=%0d d=%0h want 0/0/1/0/0",
                         bus.regWrite, bus.b_count, bus.b_ready, bus.rd, bus.writeData); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL midrst_ghost%0d: got we=%0b rd=%0d", k, bus.regWrite, bus.rd); end
    end
  endtask

  task automatic test_random();
    int starve;
    logic m_we;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_wd;
    logic [ENT_W-1:0] e;
    logic rst_now, forced, hazard, exp_a_ready, exp_b_ready, exp_rs, exp_rt, a_write, nonempty;
    do_reset();
    exp_q.delete();
    starve = 0; m_we = 1'b0; m_rd = '0; m_wd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_now     = ($urandom_range(0, 59) == 0);
      reset       = rst_now;
      bus.a_valid = ($urandom_range(0, 9) < 7);
      bus.a_rd    = ADDR_W'($urandom_range(0, 7));
      bus.a_data  = $urandom;
      bus.b_valid = ($urandom_range(0, 1) == 1);
      bus.b_rd    = ADDR_W'($urandom_range(0, 7));
      bus.b_data  = $urandom;
      bus.q_rs    = ADDR_W'($urandom_range(0, 7));
      bus.q_rt    = ADDR_W'($urandom_range(0, 7));
      #1;
      forced      = (exp_q.size() > 0) && (starve == STARVE_MAX);
      hazard      = (bus.a_rd != 0) && model_holds(bus.a_rd);
      exp_a_ready = !forced && !hazard;
      exp_b_ready = (exp_q.size() != BUF_DEPTH);
      exp_rs      = (bus.q_rs != 0) && (model_holds(bus.q_rs) || (m_we && m_rd == bus.q_rs));
      exp_rt      = (bus.q_rt != 0) && (model_holds(bus.q_rt) || (m_we && m_rd == bus.q_rt));
      checks++; if (bus.a_ready !== exp_a_ready) begin errors++; $display("FAIL rnd_a_ready c%0d: got %0b want %0b", cyc, bus.a_ready, exp_a_ready); end
      checks++; if (bus.b_ready !== exp_b_ready) begin errors++; $display("FAIL rnd_b_ready c%0d: got %0b want %0b", cyc, bus.b_ready, exp_b_ready); end
      checks++; if (bus.q_rs_pending !== exp_rs || bus.q_rt_pending !== exp_rt) begin
        errors++; $display("FAIL rnd_pending c%0d: got rs=%0b rt=%0b want %0b/%0b", cyc, bus.q_rs_pending, bus.q_rt_pending, exp_rs, exp_rt); end
      if (rst_now) begin
        exp_q.delete();
        starve = 0; m_we = 1'b0; m_rd = '0; m_wd = '0;
      end else begin
        nonempty = (exp_q.size() > 0);
        a_write  = bus.a_valid && exp_a_ready && (bus.a_rd != 0);
        if (a_write) begin
          m_we = 1'b1; m_rd = bus.a_rd; m_wd = bus.a_data;
        end else if (nonempty) begin
          e = exp_q.pop_front();
          m_we = 1'b1; m_rd = e[ENT_W-1:DATA_W]; m_wd = e[DATA_W-1:0];
        end else begin
          m_we = 1'b0;
        end
        if (!nonempty || !a_write) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (bus.b_valid && exp_b_ready && bus.b_rd != 0) exp_q.push_back({bus.b_rd, bus.b_data});
      end
      tick();
      reset = 1'b0;
      checks++; if (bus.regWrite !== m_we || bus.rd !== m_rd || bus.writeData !== m_wd) begin
        errors++; $display("FAIL rnd_write c%0d: got we=%0b rd=%0d d=%0h want we=%0b rd=%0d d=%0h",
                           cyc, bus.regWrite, bus.rd, bus.writeData, m_we, m_rd, m_wd); end
      checks++; if (bus.b_count !== 2'(exp_q.size())) begin
        errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, bus.b_count, exp_q.size()); end
    end
    drive_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_idle();
    test_reset();
    test_a_only();
    test_starvation();
    test_order_hazard();
    test_zero_reg();
    test_pending();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
